// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: core-side request/response and data-memory handshake signals of the LSU
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;
  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, core_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, core_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit bridging core data requests to a word-addressed memory
module riscv_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic      clk_i,
  input  logic      rst_i,
  riscv_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, we_q, we_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   addr_q, addr_d, wd_q, wd_d, rd_q, rd_d;
  logic          idle, bad, we, u, req, stall;
  logic [2:0]    size;
  logic [31:0]   addr, wd, ld, mem_wd;
  logic [15:0]   lane;
  logic [3:0]    be;
  // Effective access: live core inputs while IDLE, latched copies afterwards
  always_comb begin
    idle   = state_q == IDLE;
    we     = idle ? bus.core_we_i : we_q;
    size   = idle ? bus.core_size_i : size_q;
    addr   = idle ? bus.core_addr_i : addr_q;
    wd     = idle ? bus.core_wd_i : wd_q;
    u      = size[2];
    bad    = (size[1:0] == 2'd3) | (size[2] & size[1]) | ((size[1:0] == 2'd1) & addr[0]) |
             ((size[1:0] == 2'd2) & (addr[1:0] != 2'd0));
    lane   = 16'(bus.mem_rd_i >> {addr[1:0], 3'b000});
    ld     = size[1] ? bus.mem_rd_i : size[0] ? {{16{~u & lane[15]}}, lane} : {{24{~u & lane[7]}}, lane[7:0]};
    be     = size[1] ? 4'hF : size[0] ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
    mem_wd = size[1] ? wd : size[0] ? {2{wd[15:0]}} : {4{wd[7:0]}};
  end
  // Next-state, latch updates and handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    req     = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.core_req_i) begin
        stall = 1'b1;
        err_d = bad;
        if (bad) begin
          rd_d    = '0;
          state_d = DONE;
        end else begin
          req    = 1'b1;
          we_d   = bus.core_we_i;
          size_d = bus.core_size_i;
          addr_d = bus.core_addr_i;
          wd_d   = bus.core_wd_i;
          if (bus.mem_ready_i) begin
            rd_d    = we ? rd_q : ld;
            state_d = DONE;
          end else begin
            cnt_d   = CW'(1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        req   = 1'b1;
        stall = 1'b1;
        if (bus.mem_ready_i) begin
          rd_d    = we ? rd_q : ld;
          state_d = DONE;
        end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT)) begin
          err_d   = 1'b1;
          rd_d    = '0;
          state_d = DONE;
        end else if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and latch registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
    end
  end
  // Reset gates the handshake at once; memory-side fields are zero when no request is out
  assign bus.mem_req_o    = req & ~rst_i;
  assign bus.core_stall_o = stall & ~rst_i;
  assign bus.core_err_o   = (state_q == DONE) & err_q;
  assign bus.core_rd_o    = rd_q;
  assign bus.mem_we_o     = bus.mem_req_o & we;
  assign bus.mem_be_o     = bus.mem_req_o ? be : 4'h0;
  assign bus.mem_addr_o   = bus.mem_req_o ? {addr[31:2], 2'b00} : '0;
  assign bus.mem_wd_o     = bus.mem_req_o ? mem_wd : '0;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed accesses against a scoreboard of reference-model results
module tb_riscv_lsu;
  localparam int TO = 4;
  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stalls;
    int          reqs;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] model_rd = '0;
  exp_t sb[$];
  riscv_lsu_if bus();
  riscv_lsu #(.TIMEOUT(TO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_bad(input logic [2:0] size, input logic [31:0] addr);
    case (size)
      3'd0, 3'd4: m_bad = 1'b0;
      3'd1, 3'd5: m_bad = addr[0];
      3'd2:       m_bad = addr[1:0] != 2'b00;
      default:    m_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] addr);
    case (size)
      3'd0, 3'd4: m_be = 4'b0001 << addr[1:0];
      3'd1, 3'd5: m_be = addr[1] ? 4'b1100 : 4'b0011;
      default:    m_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      3'd0, 3'd4: m_wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      3'd1, 3'd5: m_wd = {wd[15:0], wd[15:0]};
      default:    m_wd = wd;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] mrd);
    logic [7:0]  b;
    logic [15:0] h;
    b = mrd[8*addr[1:0] +: 8];
    h = addr[1] ? mrd[31:16] : mrd[15:0];
    case (size)
      3'd0:    m_ld = {{24{b[7]}}, b};
      3'd4:    m_ld = {24'h0, b};
      3'd1:    m_ld = {{16{h[15]}}, h};
      3'd5:    m_ld = {16'h0, h};
      default: m_ld = mrd;
    endcase
  endfunction

  task automatic access(input string tag, input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] mrd, input int lat);
    exp_t e, g;
    int n, rq;
    logic        o_we;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wd;
    e.err    = m_bad(size, addr) || lat > TO;
    e.stalls = m_bad(size, addr) ? 1 : (lat > TO ? TO + 1 : lat + 1);
    e.reqs   = m_bad(size, addr) ? 0 : e.stalls;
    e.we     = m_bad(size, addr) ? 1'b0 : we;
    e.be     = m_bad(size, addr) ? 4'h0 : m_be(size, addr);
    e.addr   = m_bad(size, addr) ? 32'h0 : {addr[31:2], 2'b00};
    e.wd     = m_bad(size, addr) ? 32'h0 : m_wd(size, wd);
    model_rd = e.err ? 32'h0 : we ? model_rd : m_ld(size, addr, mrd);
    e.rd     = model_rd;
    sb.push_back(e);
    @(negedge clk);
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = we;
    bus.core_size_i = size;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
    bus.mem_rd_i    = mrd;
    n = 0; rq = 0; o_we = 0; o_be = 0; o_addr = 0; o_wd = 0;
    forever begin
      if (n >= 1) begin
        bus.core_req_i  = 1'b0;
        bus.core_we_i   = ~we;
        bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'hFFFF_FFFF;
        bus.core_wd_i   = 32'h0;
      end
      bus.mem_ready_i = (n == lat);
      #1;
      if (!bus.core_stall_o || n >= 40) break;
      if (bus.mem_req_o) begin
        rq++;
        o_we = bus.mem_we_o; o_be = bus.mem_be_o; o_addr = bus.mem_addr_o; o_wd = bus.mem_wd_o;
      end
      n++;
      @(negedge clk);
    end
    g = sb.pop_front();
    chk({tag, ".stall_end"}, {31'h0, bus.core_stall_o}, 32'h0);
    chk({tag, ".rd"}, bus.core_rd_o, g.rd);
    chk({tag, ".err"}, {31'h0, bus.core_err_o}, {31'h0, g.err});
    chk({tag, ".stalls"}, n, g.stalls);
    chk({tag, ".reqs"}, rq, g.reqs);
    chk({tag, ".we"}, {31'h0, o_we}, {31'h0, g.we});
    chk({tag, ".be"}, {28'h0, o_be}, {28'h0, g.be});
    chk({tag, ".addr"}, o_addr, g.addr);
    chk({tag, ".wd"}, o_wd, g.wd);
    bus.core_req_i  = 1'b0;
    bus.mem_ready_i = 1'b0;
  endtask

  initial begin
    bus.core_req_i = 0; bus.core_we_i = 0; bus.core_size_i = 0; bus.core_addr_i = 0;
    bus.core_wd_i = 0; bus.mem_rd_i = 0; bus.mem_ready_i = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset.stall", {31'h0, bus.core_stall_o}, 32'h0);
    chk("reset.mem_req", {31'h0, bus.mem_req_o}, 32'h0);
    chk("reset.rd", bus.core_rd_o, 32'h0);
    chk("reset.err", {31'h0, bus.core_err_o}, 32'h0);
    rst = 1'b0;
    access("lw_fast", 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    access("lb_slow", 1'b0, 3'd0, 32'h103, 32'h0, 32'h80123456, 3);
    access("lbu_slow", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80123456, 3);
    access("sh", 1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 1);
    access("lh_hi", 1'b0, 3'd1, 32'h102, 32'h0, 32'h80017FFF, 0);
    access("lhu_lo", 1'b0, 3'd5, 32'h000, 32'h0, 32'h80017FFF, 2);
    access("lb_pos", 1'b0, 3'd0, 32'h041, 32'h0, 32'h11227F33, 1);
    access("sb", 1'b1, 3'd0, 32'h101, 32'h7777775A, 32'h0, 0);
    access("sw", 1'b1, 3'd2, 32'h208, 32'hCAFEF00D, 32'h0, 2);
    access("lw_mis", 1'b0, 3'd2, 32'h101, 32'h0, 32'h12345678, 0);
    access("lh_mis", 1'b0, 3'd1, 32'h003, 32'h0, 32'h12345678, 0);
    access("size3", 1'b0, 3'd3, 32'h000, 32'h0, 32'h12345678, 0);
    access("size6", 1'b1, 3'd6, 32'h010, 32'h55, 32'h0, 0);
    access("lw_lat_max", 1'b0, 3'd2, 32'h010, 32'h0, 32'hA5A5_0F0F, TO);
    access("lw_timeout", 1'b0, 3'd2, 32'h300, 32'h0, 32'h12345678, 99);
    access("lw_after_to", 1'b0, 3'd2, 32'h304, 32'h0, 32'h01020304, 1);
    @(negedge clk);
    bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_size_i = 3'd2;
    bus.core_addr_i = 32'h200; bus.mem_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("busy.mem_req", {31'h0, bus.mem_req_o}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async.mem_req", {31'h0, bus.mem_req_o}, 32'h0);
    chk("rst_async.stall", {31'h0, bus.core_stall_o}, 32'h0);
    chk("rst_async.rd", bus.core_rd_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.core_req_i = 1'b0;
    model_rd = 32'h0;
    #1;
    chk("post_rst.stall", {31'h0, bus.core_stall_o}, 32'h0);
    access("lw_post_rst", 1'b0, 3'd2, 32'h204, 32'h0, 32'h0BADF00D, 1);
    access("lbu_post_rst", 1'b0, 3'd4, 32'h206, 32'h0, 32'h00C30000, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
